// File: rtl/network_mac_requant_pkg.sv
// ---------------------------------------------------------------------------
// network_mac_pkg
//   Shared constants and types for the MAC/requantisation stage that follows
//   the 16s x 14s product multiplier in the convolution datapath.
//   - PROD_W / ACC_W / OUT_W : default product, accumulator and activation widths
//   - OUT_MAX / OUT_MIN      : saturation limits of the default activation format
//   - state_e                : window state (EMPTY = no beat yet, ACCUM = mid-window)
// ---------------------------------------------------------------------------
package network_mac_pkg;

  localparam int PROD_W = 30;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 16;

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/network_mac_requant_if.sv
// ---------------------------------------------------------------------------
// network_mac_requant_if
//   Product-in / activation-out handshake bundle of network_mac_requant.
//   Input side : in_valid, in_ready, in_data (signed product), in_last, bias
//   Output side: out_valid, out_ready, out_data (signed activation)
//   Modports:
//     slave  - the MAC block (consumes products, produces activations)
//     master - the surrounding datapath (drives products, takes activations)
// ---------------------------------------------------------------------------
interface network_mac_requant_if #(
  parameter int PROD_W = network_mac_pkg::PROD_W,
  parameter int OUT_W  = network_mac_pkg::OUT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_data;
  logic              in_last;
  logic [OUT_W-1:0]  bias;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport slave (
    input  in_valid, in_data, in_last, bias, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_last, bias, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/network_mac_requant_round_sat.sv
// ---------------------------------------------------------------------------
// network_round_sat
//   Combinational requantiser: round-half-up arithmetic right shift of an
//   ACC_W-bit signed sum by SHIFT, then saturation to OUT_W signed bits.
//   Optional macro NETWORK_MAC_RELU_EN: negative saturated results become 0.
//   Ports:
//     sum_i : ACC_W signed accumulator value
//     res_o : OUT_W signed (or ReLU-clamped) activation
// ---------------------------------------------------------------------------
module network_round_sat #(
  parameter int ACC_W = network_mac_pkg::ACC_W,
  parameter int OUT_W = network_mac_pkg::OUT_W,
  parameter int SHIFT = 14
) (
  input  logic signed [ACC_W-1:0] sum_i,
  output logic        [OUT_W-1:0] res_o
);

  // Adding half an output LSB before the arithmetic shift rounds ties
  // toward +inf, for negative as well as positive sums.
  localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_HI = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_LO = ~OUT_HI;

  logic signed [ACC_W-1:0] rounded;
  logic signed [OUT_W-1:0] sat;

  always_comb begin
    rounded = (sum_i + HALF) >>> SHIFT;

    if (rounded > OUT_HI) begin
      sat = OUT_HI[OUT_W-1:0];
    end else if (rounded < OUT_LO) begin
      sat = OUT_LO[OUT_W-1:0];
    end else begin
      sat = rounded[OUT_W-1:0];
    end

`ifdef NETWORK_MAC_RELU_EN
    res_o = sat[OUT_W-1] ? '0 : sat;
`else
    res_o = sat;
`endif
  end

endmodule

// File: rtl/network_mac_requant.sv
// ---------------------------------------------------------------------------
// network_mac_requant
//   Accumulates one kernel window of signed products, adds the per-channel
//   bias (sampled on the first beat, pre-scaled by 2^SHIFT), requantises via
//   network_round_sat and holds one activation in an output register.
//   Optional macro NETWORK_MAC_RELU_EN (handled in network_round_sat) fuses
//   a ReLU onto the result; handshake and latency are unchanged.
//   Ports:
//     ap_clk   : clock, rising edge
//     ap_rst_n : asynchronous active-low reset
//     bus      : network_mac_requant_if.slave (product in, activation out)
//     ovf_err  : sticky, a window ran past MAX_TERMS beats
// ---------------------------------------------------------------------------
module network_mac_requant #(
  parameter int PROD_W    = network_mac_pkg::PROD_W,
  parameter int ACC_W     = network_mac_pkg::ACC_W,
  parameter int OUT_W     = network_mac_pkg::OUT_W,
  parameter int SHIFT     = 14,
  parameter int MAX_TERMS = 256
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  network_mac_requant_if.slave        bus,
  output logic                        ovf_err
);

  import network_mac_pkg::*;

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  if (ACC_W < PROD_W + $clog2(MAX_TERMS) + 1 || ACC_W < OUT_W + SHIFT || SHIFT < 1) begin : g_bad_cfg
    $error("network_mac_requant: ACC_W too narrow or SHIFT < 1");
  end

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;

  logic                    in_ready;
  logic                    beat;
  logic                    cnt_at_max;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic [OUT_W-1:0]        rs_data;

  // The single output register may be overwritten in the same cycle it drains.
  assign in_ready   = !out_valid_q || bus.out_ready;
  assign beat       = bus.in_valid && in_ready;
  assign cnt_at_max = (cnt_q == CNT_W'(MAX_TERMS));

  assign prod_ext = {{(ACC_W-PROD_W){bus.in_data[PROD_W-1]}}, bus.in_data};
  assign bias_ext = {{(ACC_W-OUT_W-SHIFT){bus.bias[OUT_W-1]}}, bus.bias, {SHIFT{1'b0}}};

  // Next accumulator value for an accepted beat; the first beat of a window
  // starts from the scaled bias instead of the (cleared) accumulator.
  assign sum = (state_q == EMPTY) ? bias_ext + prod_ext : acc_q + prod_ext;

  network_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .sum_i (sum),
    .res_o (rs_data)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    ovf_d       = ovf_q;

    if (beat) begin
      if (bus.in_last) begin
        state_d     = EMPTY;
        acc_d       = '0;
        cnt_d       = '0;
        out_data_d  = rs_data;
        out_valid_d = 1'b1;
      end else begin
        state_d = ACCUM;
        acc_d   = sum;
        // Past MAX_TERMS the count parks at the limit so the error keeps
        // tracking; the accumulator itself simply wraps at ACC_W.
        if (cnt_at_max) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_network_mac_requant.sv
// ---------------------------------------------------------------------------
// tb_network_mac_requant
//   Self-checking bench for network_mac_requant (MAX_TERMS = 4 so the
//   overflow path is reachable). Table of directed windows, hand-written
//   backpressure / overflow / mid-window reset sequences, then randomized
//   traffic scored against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_network_mac_requant;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ovf_err;

  always #5 ap_clk = ~ap_clk;

  network_mac_requant_if #(.PROD_W(30), .OUT_W(16)) bus ();

  network_mac_requant #(
    .PROD_W    (30),
    .ACC_W     (40),
    .OUT_W     (16),
    .SHIFT     (14),
    .MAX_TERMS (4)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .ovf_err  (ovf_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: exact integer sum, round half toward +inf, clamp, optional ReLU.
  function automatic int relu(input int v);
`ifdef NETWORK_MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int model_out(input longint s);
    longint r;
    r = (s + 64'sd8192) >>> 14;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return relu(int'(r));
  endfunction

  function automatic int out_s();
    return int'($signed(bus.out_data));
  endfunction

  typedef struct {
    int n;
    int d0, d1, d2, d3;
    int b;
    int exp;  // signed saturated result before the optional ReLU
  } vec_t;

  function automatic int pick(input vec_t v, input int k);
    case (k)
      0: return v.d0;
      1: return v.d1;
      2: return v.d2;
      default: return v.d3;
    endcase
  endfunction

  // Drive one beat; wait (bounded) for in_ready; return at posedge+1.
  task automatic send_beat(input int d, input int b, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 30'(d);
    bus.bias     = 16'(b);
    bus.in_last  = last;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check("beat_accepted", longint'(bus.in_ready), 1);
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #3;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  vec_t tbl[12];
  int   exp_q[$];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;

    tbl[0]  = '{1, 49152, 0, 0, 0, 0, 3};
    tbl[1]  = '{1, 8192, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, -8192, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, -8193, 0, 0, 0, 0, -1};
    tbl[4]  = '{1, 0, 0, 0, 0, 2, 2};
    tbl[5]  = '{4, 536870911, 536870911, 536870911, 536870911, 0, 32767};
    tbl[6]  = '{4, -536870912, -536870912, -536870912, -536870912, 0, -32768};
    tbl[7]  = '{2, 16384, 16384, 0, 0, -1, 1};
    tbl[8]  = '{1, 0, 0, 0, 0, -32768, -32768};
    tbl[9]  = '{1, 49152, 0, 0, 0, 32767, 32767};
    tbl[10] = '{3, -16384, -16384, 8191, 0, 0, -2};
    tbl[11] = '{3, 8192, 0, 0, 0, 1, 2};

    // ---- reset state ----
    #22 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_ovf_err", longint'(ovf_err), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);

    // ---- table of windows, result checked one cycle after the last beat ----
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        send_beat(pick(tbl[i], k), tbl[i].b, k == tbl[i].n - 1);
      end
      check($sformatf("tbl%0d_valid", i), longint'(bus.out_valid), 1);
      check($sformatf("tbl%0d_data", i), out_s(), relu(tbl[i].exp));
    end
    @(posedge ap_clk); #1;
    check("tbl_valid_drops", longint'(bus.out_valid), 0);

    // ---- backpressure: result held, input stalled, then replaced with no bubble ----
    bus.out_ready = 1'b0;
    send_beat(49152, 0, 1'b1);
    check("bp_first_valid", longint'(bus.out_valid), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 30'(32768);
    bus.bias     = '0;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready_low", longint'(bus.in_ready), 0);
      check("bp_data_stable", out_s(), 3);
      check("bp_valid_held", longint'(bus.out_valid), 1);
      @(posedge ap_clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", longint'(bus.in_ready), 1);
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("bp_replace_valid", longint'(bus.out_valid), 1);
    check("bp_replace_data", out_s(), 2);
    @(posedge ap_clk); #1;
    check("bp_drain_valid", longint'(bus.out_valid), 0);

    // ---- overflow: 5 beats with no last on a MAX_TERMS=4 build ----
    for (int k = 0; k < 4; k++) send_beat(16384, 0, 1'b0);
    check("ovf_not_at_max", longint'(ovf_err), 0);
    send_beat(16384, 0, 1'b0);
    check("ovf_set", longint'(ovf_err), 1);
    send_beat(16384, 0, 1'b1);
    check("ovf_window_data", out_s(), 6);
    send_beat(49152, 0, 1'b1);
    check("ovf_next_window_data", out_s(), 3);
    check("ovf_sticky", longint'(ovf_err), 1);
    do_reset();
    check("ovf_cleared_by_reset", longint'(ovf_err), 0);

    // ---- reset mid-window discards the partial sum ----
    send_beat(16384, 0, 1'b0);
    send_beat(16384, 0, 1'b0);
    ap_rst_n = 1'b0;
    #2;
    check("midrst_valid", longint'(bus.out_valid), 0);
    #1 ap_rst_n = 1'b1;
    send_beat(16384, 0, 1'b1);
    check("midrst_data", out_s(), 1);
    @(posedge ap_clk); #1;

    // ---- randomized traffic against the reference model ----
    begin
      int     win_pos = 0;
      int     win_len = 0;
      longint msum    = 0;
      int     cyc;
      logic signed [29:0] d;
      logic signed [15:0] b;

      for (cyc = 0; cyc < 6000; cyc++) begin
        if (cyc >= 3000 && win_pos == 0) break;
        if (win_len == 0) win_len = int'($urandom_range(1, 4));
        if ($urandom % 2 == 0) d = 30'($urandom);
        else                   d = 30'(int'($urandom_range(0, 131071)) - 65536);
        if ($urandom % 2 == 0) b = 16'($urandom);
        else                   b = 16'(int'($urandom_range(0, 255)) - 128);
        bus.in_valid  = ($urandom % 4) != 0;
        bus.in_data   = d;
        bus.bias      = b;
        bus.in_last   = (win_pos == win_len - 1);
        bus.out_ready = ($urandom % 3) != 0;
        #1;
        check("rand_in_ready", longint'(bus.in_ready),
              longint'(!bus.out_valid || bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("rand_unexpected_result", 1, 0);
          else check("rand_data", out_s(), exp_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
          if (win_pos == 0) msum = longint'(b) * 16384 + longint'(d);
          else              msum = msum + longint'(d);
          win_pos++;
          if (bus.in_last) begin
            exp_q.push_back(model_out(msum));
            win_pos = 0;
            win_len = 0;
          end
        end
        @(posedge ap_clk); #1;
      end
      check("rand_window_closed", win_pos, 0);

      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        #1;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) check("drain_unexpected_result", 1, 0);
          else check("drain_data", out_s(), exp_q.pop_front());
        end
        @(posedge ap_clk); #1;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      check("rand_no_ovf", longint'(ovf_err), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/network_mac_requant.md
Name: network_mac_requant

Overview:
- Downstream consumer of the 16s x 14s -> 30-bit signed product stage in the convolution datapath.
- Accumulates a stream of signed 30-bit products over one kernel window and adds a per-channel bias.
- Rounds and arithmetic-shifts the sum back to the 16-bit activation format, then saturates.
- Emits one 16-bit activation per window to the next layer over a valid/ready handshake.

Parameters:
- PROD_W, 30, input product width (signed).
- ACC_W, 40, accumulator width (signed); must be at least PROD_W + clog2(MAX_TERMS) + 1.
- OUT_W, 16, output activation width (signed).
- SHIFT, 14, right-shift applied to the accumulator for requantisation; must be at least 1.
- MAX_TERMS, 256, maximum number of products per window.

Ports:
- ap_clk, in, 1, clock; all state changes on the rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, product beat valid.
- in_ready, out, 1, block accepts a beat this cycle.
- in_data, in, PROD_W, signed product.
- in_last, in, 1, final beat of the window.
- bias, in, OUT_W, signed bias; sampled on the first beat of each window.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, OUT_W, signed saturated activation.
- ovf_err, out, 1, sticky: window exceeded MAX_TERMS.

Behaviour:
- Reset (async assert, sync release) clears acc, term counter cnt, bias register, out_valid, out_data and ovf_err to 0.
- A beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). It stalls only while the single output register is occupied and not draining.
- States:
  - EMPTY (cnt==0): an accepted beat sets acc <= sext(in_data) + (sext(bias) << SHIFT) and cnt <= 1, then moves to ACCUM.
  - ACCUM: an accepted beat sets acc <= acc + sext(in_data) and cnt <= cnt+1.
- Accepted beat with in_last, in either state:
  - sum = next acc value.
  - out_data <= sat(round(sum)), out_valid <= 1.
  - acc and cnt cleared; return to EMPTY.
  - A single-beat window (first and last together) includes the bias.
- round(x) = (x + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
- sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. All arithmetic is two's complement at ACC_W.
- Latency: result visible one cycle after the last beat is accepted.
- out_valid drops the cycle after out_valid && out_ready unless a new last beat is accepted that same cycle; in that case out_data is replaced and out_valid stays 1 (full throughput).
- out_data holds stable while out_valid && !out_ready.
- Overflow: an accepted beat with cnt==MAX_TERMS and !in_last sets ovf_err. Accumulation continues (wraps modulo ACC_W). ovf_err clears only on reset.
- A reset asserted mid-window discards the partial sum; the next beat is treated as a first beat.
- No gaps are required between windows; idle cycles within a window are allowed.

Optional Feature:
- NETWORK_MAC_RELU_EN defined: after saturation, negative results are forced to 0 (fused ReLU).
- Undefined: signed saturated result passed through unchanged.
- Handshake and latency are identical in both builds.

Decomposition:
- Package network_mac_pkg holds:
  - Width constants (PROD_W, ACC_W, OUT_W defaults).
  - OUT_MAX/OUT_MIN constants.
  - A typedef for the 2-state enum (EMPTY, ACCUM).
- One combinational sub-module, network_round_sat (ACC_W in, OUT_W out, SHIFT param), performs rounding, saturation and the optional ReLU. This isolates it for unit test.

Test Plan:
- Single beat, in_data=49152 (3<<14), bias=0, in_last=1 -> out_data=3 one cycle later, out_valid=1.
- Rounding: single beats of 8192 -> 1; -8192 -> 0; -8193 -> -1; bias=2 with in_data=0 -> 2.
- Saturation:
  - 4 beats of 536870911 -> 32767.
  - 4 beats of -536870912 -> -32768, or 0 with NETWORK_MAC_RELU_EN.
- Backpressure: hold out_ready=0 after a result -> in_ready=0, out_data stable for 5 cycles. Raise out_ready with a new last beat presented -> result replaced with no bubble.
- Overflow: MAX_TERMS=4, 5 beats without in_last -> ovf_err=1 after the 5th; it persists across later windows until ap_rst_n is asserted.
- Reset mid-window after 2 beats of 16384 -> next window of one beat 16384 with last -> out_data=1 (no residue).
